keypad_scan_decoder: RTL and testbench
======================================

Name: keypad_scan_decoder

Overview:
Parametrised matrix-keypad scanner for the keypad decoder design. It drives active-low one-hot column strobes, in the same style as the 2-to-4 active-low column decoder, and steps through the columns on a programmable dwell timer. It samples the active-low row lines, rejects frames with several keys pressed at once, debounces across whole scan frames, and reports one registered key code with a single-cycle valid pulse per press.

Parameters:
COLS, 4, number of column strobes (2..16)
ROWS, 4, number of row inputs (1..16)
SCAN_DIV, 50000, clk cycles each column is held before its rows are sampled (>=2)
DEBOUNCE, 4, consecutive identical frame results needed to accept a press or release (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low parks the scanner
row_n  in  ROWS  row sense lines, active low, already synchronised externally
col_n  out  COLS  column strobes, active low, one-hot-low while scanning
key_code  out  CODE_W  accepted key index = row*COLS + col
key_valid  out  1  one-cycle pulse when a new key is accepted
key_held  out  1  high while the accepted key is considered pressed

Behaviour:
- Reset (async, rst_n=0):
  - col_n = all ones; key_code = 0; key_valid = 0; key_held = 0.
  - col_idx = 0, div_cnt = 0, frame accumulator cleared, debounce candidate = NONE, stable_cnt = 0, state = RELEASED.
- All outputs are registered. The first rising edge with rst_n=1 and en=1 sets col_n = ~(1<<0).
- Dwell timer:
  - div_cnt counts 0..SCAN_DIV-1.
  - At div_cnt==SCAN_DIV-1: sample row_n for col_idx, set div_cnt=0, advance col_idx (COLS-1 wraps to 0), update col_n on the same edge.
  - Frame length = COLS*SCAN_DIV cycles.
- Frame accumulator:
  - Each sample adds the number of low row bits to hit_cnt, saturating at 2.
  - If the sample holds exactly one hit and hit_cnt was 0, record hit_code = row*COLS + col_idx. Lowest row wins within a sample, but any multiple hit saturates the count anyway.
  - The sample of column COLS-1 closes the frame. Frame result: hit_cnt 0 -> NONE, 1 -> KEY(hit_code), 2 -> MULTI.
  - The accumulator clears on the same edge.
- Debounce, evaluated on each frame close:
  - If the result equals the candidate, stable_cnt increments, saturating at DEBOUNCE. Otherwise the candidate becomes the result and stable_cnt = 1.
  - Decisions fire only on the edge where stable_cnt becomes DEBOUNCE.
- State machine (RELEASED, HELD):
  - RELEASED + candidate KEY(k) reaches DEBOUNCE -> HELD; key_code = k; key_held = 1; key_valid = 1 for exactly one cycle.
  - HELD + candidate NONE reaches DEBOUNCE -> RELEASED; key_held = 0; key_code retains its last value.
  - HELD + different KEY or MULTI -> stay HELD with no new pulse. A release must be seen before the next key is accepted (no roll-over).
  - RELEASED + MULTI -> stay RELEASED (ghost rejection).
- Latency: a press that is stable from the start of a frame produces key_valid at the close of the DEBOUNCE-th frame. A press that starts mid-frame adds up to one frame.
- en=0 (synchronous effect):
  - col_n = all ones; div_cnt, col_idx, accumulator, candidate and stable_cnt are cleared; state = RELEASED; key_held = 0; key_valid = 0.
  - key_code holds its value.
  - Re-enabling restarts the scan at column 0 with a fresh frame.
- rst_n asserted mid-frame or mid-debounce: everything returns to the reset values immediately, with no pulse emitted.
- DEBOUNCE=1: a single matching frame is accepted at its close.

Decomposition:
- Shared package keypad_pkg:
  - function/constant CODE_W = clog2(ROWS*COLS), minimum 1.
  - Frame-result encoding enum {RES_NONE, RES_KEY, RES_MULTI}.
  - State enum {ST_RELEASED, ST_HELD}.
  - Helper for the one-hot-low strobe, ~(1<<idx).
- One sub-module is natural: keypad_col_strobe (dwell counter + col_idx + registered one-hot-low col_n, parametrised by COLS/SCAN_DIV, with a sample_tick and frame_end output).
- Accumulation, debounce and state machine stay in the top level.

Test Plan:
All tests use COLS=4, ROWS=4, SCAN_DIV=4, DEBOUNCE=2, frame = 16 cycles.
- Reset and scan sequence: hold rst_n=0 -> col_n=1111, key_valid=0, key_held=0. After release with en=1, col_n steps 1110, 1101, 1011, 0111, 1110, each for 4 cycles.
- Single press: the bench model pulls row 2 low whenever col_n[1]=0 -> exactly one key_valid pulse, key_code=9, key_held=1. The pulse arrives no later than 3 frames (48 cycles) after the press and does not repeat while held.
- Release: from the HELD state with key 9, stop pulling the row -> key_held falls after 2 full NONE frames; key_code stays 9; no key_valid.
- Bounce and ghost: toggle the press every frame (KEY, NONE, KEY, ...) -> no key_valid. Press (row0,col0) and (row1,col3) together -> MULTI, no key_valid, key_held stays 0.
- No roll-over: press key 9, and after acceptance add key 4 and drop key 9 -> no new pulse. Release all for 2 frames, then press key 4 -> key_valid with key_code=4.
- Enable and reset mid-operation: drop en mid-frame -> col_n=1111 on the next edge and key_held=0. Re-enable -> scan resumes at 1110. Assert rst_n during the debounce window -> no pulse, all outputs at reset values.

Source files
------------

// File: rtl/keypad_scan_decoder_pkg.sv
// Shared types and helpers for the matrix keypad scanner: frame results,
// press/release states, code width and the one-hot-low column strobe.
package keypad_pkg;

  localparam int MAX_COLS = 16;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } frame_res_t;

  typedef enum logic {
    ST_RELEASED,
    ST_HELD
  } key_state_t;

  function automatic int code_width(input int rows, input int cols);
    int w;
    w = $clog2(rows * cols);
    return (w < 1) ? 1 : w;
  endfunction

  // Callers truncate the 16-bit pattern to their own column count.
  function automatic logic [MAX_COLS-1:0] strobe_n(input logic [3:0] idx);
    return ~(16'h0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_decoder_if.sv
// Keypad-side bundle: enable and row sense in, column strobes and key report out.
interface keypad_scan_decoder_if #(
  parameter int COLS   = 4,
  parameter int ROWS   = 4,
  parameter int CODE_W = keypad_pkg::code_width(ROWS, COLS)
);

  logic              en;
  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  modport master (
    input  en, row_n,
    output col_n, key_code, key_valid, key_held
  );

  modport slave (
    output en, row_n,
    input  col_n, key_code, key_valid, key_held
  );

endinterface

// File: rtl/keypad_col_strobe.sv
// Column dwell timer: holds each active-low strobe for SCAN_DIV cycles and
// flags the sample edge for the current column and the frame-closing sample.
module keypad_col_strobe
  import keypad_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [COLS-1:0] col_n,
  output logic [3:0]      col_idx,
  output logic            sample_tick,
  output logic            frame_end
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       next_idx;
  logic             last_col;

  assign last_col    = (col_idx == 4'(COLS - 1));
  assign sample_tick = en && (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end   = sample_tick && last_col;
  assign next_idx    = last_col ? 4'd0 : col_idx + 4'd1;

  // The strobe moves on the same edge that samples the outgoing column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= 4'd0;
      col_n   <= '1;
    end else if (!en) begin
      div_cnt <= '0;
      col_idx <= 4'd0;
      col_n   <= '1;
    end else if (sample_tick) begin
      div_cnt <= '0;
      col_idx <= next_idx;
      col_n   <= COLS'(strobe_n(next_idx));
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      col_n   <= COLS'(strobe_n(col_idx));
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// Matrix keypad scanner: accumulates one frame of row samples, debounces whole
// frame results and reports each accepted press once, with no roll-over.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  keypad_scan_decoder_if.master bus
);

  localparam int CODE_W = code_width(ROWS, COLS);

  logic [3:0]        col_idx;
  logic              sample_tick;
  logic              frame_end;

  logic [1:0]        hit_cnt;
  logic [CODE_W-1:0] hit_code;
  logic [4:0]        low_cnt;
  logic [3:0]        low_row;
  logic [5:0]        hit_sum;
  logic [1:0]        hit_next;
  logic [CODE_W-1:0] code_next;
  frame_res_t        frame_res;

  frame_res_t        cand_res;
  logic [CODE_W-1:0] cand_code;
  logic [3:0]        stable_cnt;
  logic [3:0]        stable_next;
  logic              same;
  logic              fire;

  key_state_t        state;
  key_state_t        next_state;
  logic              pulse;

  keypad_col_strobe #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_strobe (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (bus.en),
    .col_n       (bus.col_n),
    .col_idx     (col_idx),
    .sample_tick (sample_tick),
    .frame_end   (frame_end)
  );

  // Descending scan leaves the lowest low row in low_row.
  always_comb begin
    low_cnt = 5'd0;
    low_row = 4'd0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!bus.row_n[r]) begin
        low_cnt = low_cnt + 5'd1;
        low_row = 4'(r);
      end
    end
    hit_sum   = 6'(hit_cnt) + 6'(low_cnt);
    hit_next  = (hit_sum >= 6'd2) ? 2'd2 : hit_sum[1:0];
    code_next = hit_code;
    if (low_cnt == 5'd1 && hit_cnt == 2'd0) begin
      code_next = CODE_W'(int'(low_row) * COLS + int'(col_idx));
    end
    case (hit_next)
      2'd0:    frame_res = RES_NONE;
      2'd1:    frame_res = RES_KEY;
      default: frame_res = RES_MULTI;
    endcase
  end

  // A decision fires only on the frame that brings the count up to DEBOUNCE.
  always_comb begin
    same = (frame_res == cand_res) &&
           (frame_res != RES_KEY || code_next == cand_code);
    if (same) begin
      stable_next = (stable_cnt >= 4'(DEBOUNCE)) ? 4'(DEBOUNCE) : stable_cnt + 4'd1;
    end else begin
      stable_next = 4'd1;
    end
    fire = frame_end && (stable_next == 4'(DEBOUNCE)) &&
           (!same || stable_cnt != 4'(DEBOUNCE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt    <= 2'd0;
      hit_code   <= '0;
      cand_res   <= RES_NONE;
      cand_code  <= '0;
      stable_cnt <= 4'd0;
    end else if (!bus.en) begin
      hit_cnt    <= 2'd0;
      hit_code   <= '0;
      cand_res   <= RES_NONE;
      cand_code  <= '0;
      stable_cnt <= 4'd0;
    end else if (sample_tick) begin
      if (frame_end) begin
        hit_cnt    <= 2'd0;
        hit_code   <= '0;
        stable_cnt <= stable_next;
        if (!same) begin
          cand_res  <= frame_res;
          cand_code <= code_next;
        end
      end else begin
        hit_cnt  <= hit_next;
        hit_code <= code_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RELEASED;
    end else begin
      state <= next_state;
    end
  end

  // Only a debounced release leaves HELD, so a second key cannot roll over.
  always_comb begin
    next_state = state;
    pulse      = 1'b0;
    if (!bus.en) begin
      next_state = ST_RELEASED;
    end else if (fire) begin
      case (state)
        ST_RELEASED: begin
          if (frame_res == RES_KEY) begin
            next_state = ST_HELD;
            pulse      = 1'b1;
          end
        end
        ST_HELD: begin
          if (frame_res == RES_NONE) begin
            next_state = ST_RELEASED;
          end
        end
        default: next_state = ST_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.key_code  <= '0;
      bus.key_valid <= 1'b0;
      bus.key_held  <= 1'b0;
    end else begin
      bus.key_valid <= pulse;
      bus.key_held  <= (next_state == ST_HELD);
      if (pulse) begin
        bus.key_code <= code_next;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder with a 4x4 keypad model driving the
// rows from the column strobes; four-cycle dwell, two-frame debounce.
module tb_keypad_scan_decoder;

  localparam int COLS     = 4;
  localparam int ROWS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = COLS * SCAN_DIV;

  localparam logic [15:0] K0 = 16'h0001;
  localparam logic [15:0] K4 = 16'h0010;
  localparam logic [15:0] K7 = 16'h0080;
  localparam logic [15:0] K9 = 16'h0200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     pressed = '0;
  logic [ROWS-1:0] row_model;
  logic [3:0]      scan_exp;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int pulses_before = 0;

  always #5 clk = ~clk;

  keypad_scan_decoder_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  keypad_scan_decoder #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // A pressed key shorts its row to its column whenever that column is strobed.
  always_comb begin
    row_model = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (pressed[r*COLS+c] && !bus.col_n[c]) row_model[r] = 1'b0;
      end
    end
  end
  assign bus.row_n = row_model;

  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) pulse_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic enable);
    pressed = keys;
    bus.en  = enable;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that closed a frame and restarted column 0.
  task automatic sync_frame();
    logic [3:0] prev;
    logic       found;
    prev  = bus.col_n;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (prev == 4'b0111 && bus.col_n == 4'b1110) found = 1'b1;
      prev = bus.col_n;
    end
    checkOutput("frame_sync", 32'(found), 32'd1);
  endtask

  initial begin
    applyStimulus('0, 1'b1);
    rst_n = 1'b0;
    tick(3);
    checkOutput("reset_col_n", 32'(bus.col_n), 32'hF);
    checkOutput("reset_valid", 32'(bus.key_valid), 32'd0);
    checkOutput("reset_held", 32'(bus.key_held), 32'd0);
    checkOutput("reset_code", 32'(bus.key_code), 32'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      scan_exp = ~(4'b0001 << ((k / SCAN_DIV) % COLS));
      checkOutput("scan_col_n", 32'(bus.col_n), 32'(scan_exp));
    end

    sync_frame();
    applyStimulus(K9, 1'b1);
    pulses_before = pulse_cnt;
    tick(2 * FRAME - 1);
    checkOutput("press_early", 32'(bus.key_valid), 32'd0);
    tick(1);
    checkOutput("press_valid", 32'(bus.key_valid), 32'd1);
    checkOutput("press_code", 32'(bus.key_code), 32'd9);
    checkOutput("press_held", 32'(bus.key_held), 32'd1);
    tick(1);
    checkOutput("press_pulse_width", 32'(bus.key_valid), 32'd0);
    tick(2 * FRAME);
    checkOutput("press_once", 32'(pulse_cnt - pulses_before), 32'd1);
    checkOutput("press_still_held", 32'(bus.key_held), 32'd1);

    sync_frame();
    applyStimulus('0, 1'b1);
    pulses_before = pulse_cnt;
    tick(2 * FRAME - 1);
    checkOutput("release_early", 32'(bus.key_held), 32'd1);
    tick(1);
    checkOutput("release_held", 32'(bus.key_held), 32'd0);
    checkOutput("release_code", 32'(bus.key_code), 32'd9);
    checkOutput("release_no_pulse", 32'(pulse_cnt - pulses_before), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2 == 0) ? K9 : 16'h0000, 1'b1);
      tick(FRAME);
    end
    checkOutput("bounce_no_pulse", 32'(pulse_cnt - pulses_before), 32'd0);
    checkOutput("bounce_held", 32'(bus.key_held), 32'd0);

    applyStimulus(K0 | K7, 1'b1);
    tick(4 * FRAME);
    checkOutput("ghost_no_pulse", 32'(pulse_cnt - pulses_before), 32'd0);
    checkOutput("ghost_held", 32'(bus.key_held), 32'd0);
    checkOutput("ghost_code", 32'(bus.key_code), 32'd9);
    applyStimulus('0, 1'b1);
    tick(2 * FRAME);

    applyStimulus(K9, 1'b1);
    pulses_before = pulse_cnt;
    tick(2 * FRAME);
    checkOutput("roll_first_valid", 32'(bus.key_valid), 32'd1);
    checkOutput("roll_first_code", 32'(bus.key_code), 32'd9);
    applyStimulus(K4, 1'b1);
    tick(4 * FRAME);
    checkOutput("roll_no_new_pulse", 32'(pulse_cnt - pulses_before), 32'd1);
    checkOutput("roll_held", 32'(bus.key_held), 32'd1);
    checkOutput("roll_code_kept", 32'(bus.key_code), 32'd9);
    applyStimulus('0, 1'b1);
    tick(2 * FRAME);
    checkOutput("roll_released", 32'(bus.key_held), 32'd0);
    applyStimulus(K4, 1'b1);
    tick(2 * FRAME);
    checkOutput("roll_second_valid", 32'(bus.key_valid), 32'd1);
    checkOutput("roll_second_code", 32'(bus.key_code), 32'd4);

    tick(5);
    applyStimulus(K4, 1'b0);
    tick(1);
    checkOutput("disable_col_n", 32'(bus.col_n), 32'hF);
    checkOutput("disable_held", 32'(bus.key_held), 32'd0);
    checkOutput("disable_valid", 32'(bus.key_valid), 32'd0);
    checkOutput("disable_code", 32'(bus.key_code), 32'd4);
    tick(2);
    applyStimulus(K4, 1'b1);
    tick(1);
    checkOutput("reenable_col_n", 32'(bus.col_n), 32'hE);
    tick(2 * FRAME - 1);
    checkOutput("reenable_valid", 32'(bus.key_valid), 32'd1);
    checkOutput("reenable_code", 32'(bus.key_code), 32'd4);

    applyStimulus('0, 1'b1);
    tick(2 * FRAME);
    checkOutput("pre_reset_released", 32'(bus.key_held), 32'd0);
    applyStimulus(K9, 1'b1);
    pulses_before = pulse_cnt;
    tick(FRAME + 4);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_col_n", 32'(bus.col_n), 32'hF);
    checkOutput("midreset_valid", 32'(bus.key_valid), 32'd0);
    checkOutput("midreset_held", 32'(bus.key_held), 32'd0);
    checkOutput("midreset_code", 32'(bus.key_code), 32'd0);
    tick(3 * FRAME);
    checkOutput("midreset_no_pulse", 32'(pulse_cnt - pulses_before), 32'd0);
    rst_n = 1'b1;
    tick(2 * FRAME);
    checkOutput("post_reset_valid", 32'(bus.key_valid), 32'd1);
    checkOutput("post_reset_code", 32'(bus.key_code), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
